// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op codes, FSM states and the
// single-cycle result/flag function used by the core.
package alu_seq_pkg;

    // Widest operand the single-cycle function can evaluate.
    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] ONE_W = {{(MAX_W-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [MAX_W-1:0] result;
        logic             carry;
        logic             overflow;
    } alu_res_t;

    // Single-cycle ops evaluated on the low w bits; unknown codes fall back to ADD.
    // SLT reuses the subtract path, so its sign/overflow come from A-B.
    function automatic alu_res_t alu_single(input logic [3:0]       op,
                                            input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input int               w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] am;
        logic [MAX_W-1:0] bop;
        logic [MAX_W-1:0] sum_w;
        logic [MAX_W:0]   sum;
        logic             use_sub;
        logic             a_n;
        logic             b_n;
        logic             s_n;
        logic             ovf;
        alu_res_t         r;

        mask    = (ONE_W << w) - ONE_W;
        msb     = ONE_W << (w - 1);
        use_sub = (op == OP_SUB) || (op == OP_SLT);
        am      = a & mask;
        bop     = (use_sub ? ~b : b) & mask;
        sum     = {1'b0, am} + {1'b0, bop} + {{MAX_W{1'b0}}, use_sub};
        sum_w   = sum[MAX_W-1:0] & mask;
        a_n     = |(am & msb);
        b_n     = |(bop & msb);
        s_n     = |(sum_w & msb);
        ovf     = (a_n == b_n) && (s_n != a_n);

        r = '0;
        case (op)
            OP_AND:  r.result = am & b;
            OP_OR:   r.result = (a | b) & mask;
            OP_SLT:  r.result = {{(MAX_W-1){1'b0}}, s_n ^ ovf};
            default: begin
                r.result   = sum_w;
                r.carry    = |(sum >> w);
                r.overflow = ovf;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative radix-2 unsigned multiplier and restoring divider.
// One step per cycle for WIDTH cycles; done_o is high during the final
// step and result_o then carries that step's outcome.
module muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             sel_hi_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    // acc holds {product_hi, multiplier/product_lo} for MUL and
    // {remainder, dividend/quotient} for DIV; opnd is multiplicand or divisor.
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               sel_hi_q, sel_hi_d;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // Start latches operands; afterwards one shift-add or restoring step per cycle.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = shifted - {1'b0, opnd_q};
        if (start_i) begin
            cnt_d    = CNT_W'(WIDTH);
            acc_d    = {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
            opnd_d   = is_div_i ? b_i : a_i;
            is_div_d = is_div_i;
            sel_hi_d = sel_hi_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (!is_div_q) begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done_o   = (cnt_q == CNT_W'(1));
    assign result_o = sel_hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

    // Iteration state registers; reset drops any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/slt plus iterative
// multiply/divide, with registered result and flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic [3:0]       ALU_CONTROL_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] RESULT_o,
    output logic             flag_carry_o,
    output logic             flag_zero_o,
    output logic             flag_overflow_o,
    output logic             flag_negative_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             ld_c;
    logic             ld_v;
    alu_res_t         alu_r;
    logic             alu_unused;

    assign alu_r      = alu_single(ALU_CONTROL_i, MAX_W'(A_i), MAX_W'(B_i), WIDTH);
    assign alu_unused = |(alu_r.result >> WIDTH);
    assign is_mul     = (ALU_CONTROL_i == OP_MUL) || (ALU_CONTROL_i == OP_MULHU);
    assign is_div     = (ALU_CONTROL_i == OP_DIVU) || (ALU_CONTROL_i == OP_REMU);
    assign in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == DONE);

    muldiv_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_muldiv (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (md_start),
        .is_div_i(is_div),
        .sel_hi_i(ALU_CONTROL_i[0]),
        .a_i     (A_i),
        .b_i     (B_i),
        .done_o  (md_done),
        .result_o(md_result)
    );

    // Next state, iterator start and output-register load; an accept in
    // DONE replaces the consumed result in the same cycle.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        md_start = 1'b0;
        ld       = 1'b0;
        ld_val   = md_result;
        ld_c     = 1'b0;
        ld_v     = 1'b0;
        case (state_q)
            MUL, DIV: begin
                if (md_done) begin
                    ld      = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            if (is_mul) begin
                md_start = 1'b1;
                state_d  = MUL;
            end else if (is_div) begin
                md_start = 1'b1;
                state_d  = DIV;
            end else begin
                ld      = 1'b1;
                ld_val  = alu_r.result[WIDTH-1:0];
                ld_c    = alu_r.carry;
                ld_v    = alu_r.overflow;
                state_d = DONE;
            end
        end
        if (ld) begin
            result_d = ld_val;
            carry_d  = ld_c;
            ovf_d    = ld_v;
            zero_d   = (ld_val == '0);
            neg_d    = ld_val[WIDTH-1];
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign RESULT_o        = result_q;
    assign flag_carry_o    = carry_q;
    assign flag_overflow_o = ovf_q;
    assign flag_zero_o     = zero_q;
    assign flag_negative_o = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=16.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel16;

    logic        rdy32, vld32, c32, z32, v32, n32;
    logic [31:0] res32;
    logic        rdy16, vld16, c16, z16, v16, n16;
    logic [15:0] res16;

    logic        o_ready, o_valid, o_c, o_z, o_v, o_n;
    logic [31:0] o_res;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .A_i(a), .B_i(b), .ALU_CONTROL_i(op), .out_valid_o(vld32),
        .out_ready_i(out_ready), .RESULT_o(res32), .flag_carry_o(c32),
        .flag_zero_o(z32), .flag_overflow_o(v32), .flag_negative_o(n32)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy16),
        .A_i(a[15:0]), .B_i(b[15:0]), .ALU_CONTROL_i(op), .out_valid_o(vld16),
        .out_ready_i(out_ready), .RESULT_o(res16), .flag_carry_o(c16),
        .flag_zero_o(z16), .flag_overflow_o(v16), .flag_negative_o(n16)
    );

    assign o_ready = sel16 ? rdy16 : rdy32;
    assign o_valid = sel16 ? vld16 : vld32;
    assign o_res   = sel16 ? {16'h0, res16} : res32;
    assign o_c     = sel16 ? c16 : c32;
    assign o_z     = sel16 ? z16 : z32;
    assign o_v     = sel16 ? v16 : v32;
    assign o_n     = sel16 ? n16 : n32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
        logic        n;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int lat;
        int busy_bad;
        @(negedge clk);
        check({v.name, "/in_ready"}, 64'(o_ready), 64'd1);
        in_valid = 1'b1;
        op = v.op;
        a  = v.a;
        b  = v.b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (!o_valid && lat < 200) begin
            if (o_ready) busy_bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({v.name, "/latency"}, 64'(lat), 64'(v.lat));
        check({v.name, "/result"}, 64'(o_res), 64'(v.res));
        check({v.name, "/carry"}, 64'(o_c), 64'(v.c));
        check({v.name, "/zero"}, 64'(o_z), 64'(v.z));
        check({v.name, "/overflow"}, 64'(o_v), 64'(v.v));
        check({v.name, "/negative"}, 64'(o_n), 64'(v.n));
        if (v.lat > 1) check({v.name, "/in_ready_busy"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = OP_ADD; a = '0; b = '0; sel16 = 1'b0;

        //            op         a             b             res           c     z     v     n     lat name
        vecs[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1, 1,  "add_ovf"};
        vecs[1]  = '{OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1,  "sub_zero"};
        vecs[2]  = '{OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1,  "sub_borrow"};
        vecs[3]  = '{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 1,  "add_carry"};
        vecs[4]  = '{OP_SLT,   32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "slt_neg"};
        vecs[5]  = '{OP_SLT,   32'h00000001, 32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1,  "slt_pos"};
        vecs[6]  = '{OP_AND,   32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "and"};
        vecs[7]  = '{OP_OR,    32'h80000000, 32'h00000001, 32'h80000001, 1'b0, 1'b0, 1'b0, 1'b1, 1,  "or"};
        vecs[8]  = '{4'b0100,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "undef_0100"};
        vecs[9]  = '{4'b1111,  32'h00000005, 32'h00000006, 32'h0000000B, 1'b0, 1'b0, 1'b0, 1'b0, 1,  "undef_1111"};
        vecs[10] = '{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 33, "mul_max"};
        vecs[11] = '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 33, "mulhu_max"};
        vecs[12] = '{OP_MUL,   32'h80000000, 32'h00000004, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 33, "mul_lo_zero"};
        vecs[13] = '{OP_MULHU, 32'h80000000, 32'h00000004, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 33, "mulhu_pow2"};
        vecs[14] = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0, 1'b0, 33, "divu_100_7"};
        vecs[15] = '{OP_REMU,  32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 33, "remu_100_7"};
        vecs[16] = '{OP_DIVU,  32'd12345,    32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 33, "divu_by0"};
        vecs[17] = '{OP_REMU,  32'd123,      32'd0,        32'd123,      1'b0, 1'b0, 1'b0, 1'b0, 33, "remu_by0"};
        vecs[18] = '{OP_DIVU,  32'h80000000, 32'd3,        32'h2AAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 33, "divu_big"};
        vecs[19] = '{OP_REMU,  32'h80000000, 32'd3,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 33, "remu_big"};

        repeat (2) @(posedge clk);
        #1;
        check("rst/out_valid", 64'(o_valid), 64'd0);
        check("rst/result", 64'(o_res), 64'd0);
        check("rst/flags", 64'({o_c, o_z, o_v, o_n}), 64'd0);
        check("rst/in_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) do_op(vecs[i]);

        // Reset in the middle of a multiply: no result may appear afterwards.
        @(negedge clk);
        in_valid = 1'b1; op = OP_MUL; a = 32'd7; b = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid/out_valid", 64'(o_valid), 64'd0);
        check("rst_mid/result", 64'(o_res), 64'd0);
        check("rst_mid/in_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        check("rst_mid/no_late_result", 64'(seen), 64'd0);
        do_op('{OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1, "after_rst_add"});

        // Back-to-back single-cycle ops, one result per cycle in order.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = OP_ADD; a = 32'(i * 3); b = 32'd100;
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d/out_valid", i), 64'(o_valid), 64'd1);
            check($sformatf("b2b%0d/result", i), 64'(o_res), 64'(i * 3 + 100));
        end
        // Multi-cycle op accepted straight out of DONE.
        do_op('{OP_MUL, 32'd7, 32'd9, 32'd63, 1'b0, 1'b0, 1'b0, 1'b0, 33, "mul_from_done"});

        // Back-pressure: result held, new op waits, then taken exactly once.
        @(negedge clk);
        in_valid = 1'b1; op = OP_ADD; a = 32'd10; b = 32'd20;
        @(posedge clk);
        #1;
        check("bp/first", 64'(o_res), 64'd30);
        @(negedge clk);
        out_ready = 1'b0; a = 32'd40; b = 32'd2;
        #1;
        check("bp/in_ready_low", 64'(o_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d/held_result", k), 64'(o_res), 64'd30);
            check($sformatf("bp%0d/out_valid", k), 64'(o_valid), 64'd1);
            check($sformatf("bp%0d/in_ready", k), 64'(o_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp/in_ready_release", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        check("bp/second", 64'(o_res), 64'd42);
        check("bp/second_valid", 64'(o_valid), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp/no_duplicate", 64'(o_valid), 64'd0);

        // Narrow instance.
        sel16 = 1'b1;
        do_op('{OP_MULHU, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 17, "w16_mulhu"});
        do_op('{OP_MUL,   32'h0000FFFF, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 17, "w16_mul"});
        do_op('{OP_DIVU,  32'h0000FFFF, 32'h00000010, 32'h00000FFF, 1'b0, 1'b0, 1'b0, 1'b0, 17, "w16_divu"});
        do_op('{OP_ADD,   32'h00007FFF, 32'h00000001, 32'h00008000, 1'b0, 1'b0, 1'b1, 1'b1, 1,  "w16_add_ovf"});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
